// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register specifiers and status codes.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    // Undefined status encodings are folded into INS.
    function automatic logic [2:0] norm_stat(input logic [2:0] s);
        logic [2:0] r;
        case (s)
            S_AOK, S_HLT, S_ADR, S_INS: r = s;
            default:                    r = S_INS;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_dst_sel.sv
// Destination selection for write-back: maps an instruction to its dstE/dstM.
module wb_dst_sel
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    input  logic [3:0] ra_i,
    input  logic [3:0] rb_i,
    input  logic       cnd_i,
    output logic [3:0] dst_e_o,
    output logic [3:0] dst_m_o
);

    // dstE: ALU result destination; conditional moves drop it when cnd is false.
    always_comb begin
        dst_e_o = R_NONE;
        case (icode_i)
            I_RRMOVQ:                        dst_e_o = cnd_i ? rb_i : R_NONE;
            I_IRMOVQ, I_OPQ:                 dst_e_o = rb_i;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e_o = R_RSP;
            default:                         dst_e_o = R_NONE;
        endcase
    end

    // dstM: memory-read destination, only loads and pops produce one.
    always_comb begin
        dst_m_o = R_NONE;
        case (icode_i)
            I_MRMOVQ, I_POPQ: dst_m_o = ra_i;
            default:          dst_m_o = R_NONE;
        endcase
    end

endmodule

// File: rtl/wb_regfile_writer.sv
// Write-back stage: commits dstE/dstM into the register file, tracks status and
// counts retired instructions.
module wb_regfile_writer
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'd0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic [2:0]       stat_in,
    output logic [63:0]      reg_mem0,
    output logic [63:0]      reg_mem1,
    output logic [63:0]      reg_mem2,
    output logic [63:0]      reg_mem3,
    output logic [63:0]      reg_mem4,
    output logic [63:0]      reg_mem5,
    output logic [63:0]      reg_mem6,
    output logic [63:0]      reg_mem7,
    output logic [63:0]      reg_mem8,
    output logic [63:0]      reg_mem9,
    output logic [63:0]      reg_mem10,
    output logic [63:0]      reg_mem11,
    output logic [63:0]      reg_mem12,
    output logic [63:0]      reg_mem13,
    output logic [63:0]      reg_mem14,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retire_count,
    output logic [3:0]       dstE_dbg,
    output logic [3:0]       dstM_dbg
);

    localparam int RspIdx = 4;

    logic [63:0]      regs_q [15];
    logic [2:0]       stat_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [3:0]       dst_e;
    logic [3:0]       dst_m;
    logic             accept;

    wb_dst_sel u_dst_sel (
        .icode_i (icode),
        .ra_i    (rA),
        .rb_i    (rB),
        .cnd_i   (cnd),
        .dst_e_o (dst_e),
        .dst_m_o (dst_m)
    );

    assign halted  = (stat_q != S_AOK);
    assign accept  = wb_valid && !halted;
    assign count_d = count_q + CNT_W'(1);

    // Register file, status and retire counter; valM write is issued last so it
    // wins when both ports target the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == RspIdx) ? RSP_INIT : 64'd0;
            end
            stat_q  <= S_AOK;
            count_q <= '0;
        end else if (accept) begin
            if (stat_in == S_AOK) begin
                if (dst_e != R_NONE) regs_q[dst_e] <= valE;
                if (dst_m != R_NONE) regs_q[dst_m] <= valM;
                count_q <= count_d;
            end else begin
                stat_q <= norm_stat(stat_in);
            end
        end
    end

    assign reg_mem0     = regs_q[0];
    assign reg_mem1     = regs_q[1];
    assign reg_mem2     = regs_q[2];
    assign reg_mem3     = regs_q[3];
    assign reg_mem4     = regs_q[4];
    assign reg_mem5     = regs_q[5];
    assign reg_mem6     = regs_q[6];
    assign reg_mem7     = regs_q[7];
    assign reg_mem8     = regs_q[8];
    assign reg_mem9     = regs_q[9];
    assign reg_mem10    = regs_q[10];
    assign reg_mem11    = regs_q[11];
    assign reg_mem12    = regs_q[12];
    assign reg_mem13    = regs_q[13];
    assign reg_mem14    = regs_q[14];
    assign stat         = stat_q;
    assign retire_count = count_q;
    assign dstE_dbg     = dst_e;
    assign dstM_dbg     = dst_m;

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Self-checking bench for wb_regfile_writer against an architectural model.
module tb_wb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [3:0]  icode, rA, rB;
    logic        cnd;
    logic [63:0] valE, valM;
    logic [2:0]  stat_in;
    logic [63:0] dut_regs [15];
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retire_count;
    logic [3:0]  dstE_dbg, dstM_dbg;

    // Architectural model state
    logic [63:0] m_regs [15];
    logic [2:0]  m_stat;
    logic [31:0] m_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_regfile_writer #(.RSP_INIT(64'd256), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .icode        (icode),
        .rA           (rA),
        .rB           (rB),
        .cnd          (cnd),
        .valE         (valE),
        .valM         (valM),
        .stat_in      (stat_in),
        .reg_mem0     (dut_regs[0]),
        .reg_mem1     (dut_regs[1]),
        .reg_mem2     (dut_regs[2]),
        .reg_mem3     (dut_regs[3]),
        .reg_mem4     (dut_regs[4]),
        .reg_mem5     (dut_regs[5]),
        .reg_mem6     (dut_regs[6]),
        .reg_mem7     (dut_regs[7]),
        .reg_mem8     (dut_regs[8]),
        .reg_mem9     (dut_regs[9]),
        .reg_mem10    (dut_regs[10]),
        .reg_mem11    (dut_regs[11]),
        .reg_mem12    (dut_regs[12]),
        .reg_mem13    (dut_regs[13]),
        .reg_mem14    (dut_regs[14]),
        .stat         (stat),
        .halted       (halted),
        .retire_count (retire_count),
        .dstE_dbg     (dstE_dbg),
        .dstM_dbg     (dstM_dbg)
    );

    function automatic logic [3:0] ref_dst_e(input logic [3:0] ic, input logic [3:0] b,
                                             input logic c);
        if (ic == 4'h2) return c ? b : 4'hF;
        if (ic == 4'h3 || ic == 4'h6) return b;
        if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] ref_dst_m(input logic [3:0] ic, input logic [3:0] a);
        return (ic == 4'h5 || ic == 4'hB) ? a : 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
        m_regs[4] = 64'd256;
        m_stat    = 3'd1;
        m_count   = 32'd0;
    endtask

    // One clock of stimulus; model updated as the architecture defines it.
    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic c, input logic [63:0] e,
                         input logic [63:0] m, input logic [2:0] s);
        logic [3:0] de, dm;
        wb_valid = v; icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m; stat_in = s;
        @(posedge clk);
        #1;
        if (v && m_stat == 3'd1) begin
            if (s == 3'd1) begin
                de = ref_dst_e(ic, b, c);
                dm = ref_dst_m(ic, a);
                if (de != 4'hF) m_regs[de] = e;
                if (dm != 4'hF) m_regs[dm] = m;
                m_count = m_count + 1;
            end else begin
                m_stat = (s >= 3'd2 && s <= 3'd4) ? s : 3'd4;
            end
        end
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (dut_regs[i] !== m_regs[i]) begin
                n_err++;
                $display("FAIL reset reg%0d got %h exp %h", i, dut_regs[i], m_regs[i]);
            end
        end
        n_cmp++;
        if (stat !== 3'd1 || halted !== 1'b0 || retire_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset status stat=%0d halted=%b cnt=%0d exp 1/0/0",
                     stat, halted, retire_count);
        end
    endtask

    task automatic test_irmovq();
        drive(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'd5, 64'd0, 3'd1);
        n_cmp++;
        if (dut_regs[1] !== 64'd5 || retire_count !== 32'd1) begin
            n_err++;
            $display("FAIL irmovq reg1=%0d cnt=%0d exp 5/1", dut_regs[1], retire_count);
        end
    endtask

    task automatic test_cmov();
        drive(1'b1, 4'h2, 4'h0, 4'h2, 1'b0, 64'd9, 64'd0, 3'd1);
        n_cmp++;
        if (dut_regs[2] !== 64'd0 || retire_count !== 32'd2) begin
            n_err++;
            $display("FAIL cmov_nt reg2=%0d cnt=%0d exp 0/2", dut_regs[2], retire_count);
        end
        drive(1'b1, 4'h2, 4'h0, 4'h2, 1'b1, 64'd9, 64'd0, 3'd1);
        n_cmp++;
        if (dut_regs[2] !== 64'd9 || retire_count !== 32'd3) begin
            n_err++;
            $display("FAIL cmov_t reg2=%0d cnt=%0d exp 9/3", dut_regs[2], retire_count);
        end
    endtask

    task automatic test_popq_rsp();
        drive(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'd264, 64'd77, 3'd1);
        n_cmp++;
        if (dut_regs[4] !== 64'd77) begin
            n_err++;
            $display("FAIL popq_rsp reg4 got %0d exp 77", dut_regs[4]);
        end
    endtask

    task automatic test_pushq();
        drive(1'b1, 4'hA, 4'h1, 4'hF, 1'b0, 64'd248, 64'd0, 3'd1);
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (dut_regs[i] !== m_regs[i]) begin
                n_err++;
                $display("FAIL pushq reg%0d got %h exp %h", i, dut_regs[i], m_regs[i]);
            end
        end
        n_cmp++;
        if (dut_regs[4] !== 64'd248) begin
            n_err++;
            $display("FAIL pushq_rsp reg4 got %0d exp 248", dut_regs[4]);
        end
    endtask

    task automatic test_random();
        logic [3:0] ic, a, b;
        logic       c, v;
        for (int n = 0; n < 60; n++) begin
            ic = 4'($urandom_range(0, 15));
            a  = 4'($urandom);
            b  = 4'($urandom);
            c  = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            icode = ic; rA = a; rB = b; cnd = c;
            #1;
            n_cmp++;
            if (dstE_dbg !== ref_dst_e(ic, b, c) || dstM_dbg !== ref_dst_m(ic, a)) begin
                n_err++;
                $display("FAIL rand_dst ic=%h a=%h b=%h c=%b got E=%h M=%h exp E=%h M=%h",
                         ic, a, b, c, dstE_dbg, dstM_dbg, ref_dst_e(ic, b, c),
                         ref_dst_m(ic, a));
            end
            drive(v, ic, a, b, c, {$urandom, $urandom}, {$urandom, $urandom}, 3'd1);
            for (int i = 0; i < 15; i++) begin
                n_cmp++;
                if (dut_regs[i] !== m_regs[i]) begin
                    n_err++;
                    $display("FAIL rand_reg it%0d reg%0d got %h exp %h",
                             n, i, dut_regs[i], m_regs[i]);
                end
            end
            n_cmp++;
            if (retire_count !== m_count) begin
                n_err++;
                $display("FAIL rand_cnt it%0d got %0d exp %0d", n, retire_count, m_count);
            end
        end
    endtask

    task automatic test_halt();
        logic [31:0] cnt_before;
        cnt_before = m_count;
        drive(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 3'd2);
        n_cmp++;
        if (stat !== 3'd2 || halted !== 1'b1 || retire_count !== cnt_before) begin
            n_err++;
            $display("FAIL halt stat=%0d halted=%b cnt=%0d exp 2/1/%0d",
                     stat, halted, retire_count, cnt_before);
        end
        drive(1'b1, 4'h3, 4'hF, 4'h3, 1'b0, 64'd7, 64'd0, 3'd1);
        drive(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 3'd3);
        n_cmp++;
        if (dut_regs[3] !== m_regs[3] || stat !== 3'd2 || retire_count !== cnt_before) begin
            n_err++;
            $display("FAIL halt_sticky reg3=%h stat=%0d cnt=%0d exp %h/2/%0d",
                     dut_regs[3], stat, retire_count, m_regs[3], cnt_before);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (dut_regs[i] !== m_regs[i]) begin
                n_err++;
                $display("FAIL async_rst reg%0d got %h exp %h", i, dut_regs[i], m_regs[i]);
            end
        end
        n_cmp++;
        if (stat !== 3'd1 || halted !== 1'b0 || retire_count !== 32'd0) begin
            n_err++;
            $display("FAIL async_rst status stat=%0d halted=%b cnt=%0d", stat, halted,
                     retire_count);
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_bad_stat();
        drive(1'b1, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 3'd6);
        n_cmp++;
        if (stat !== 3'd4 || halted !== 1'b1 || retire_count !== 32'd0) begin
            n_err++;
            $display("FAIL bad_stat stat=%0d halted=%b cnt=%0d exp 4/1/0",
                     stat, halted, retire_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = '0; valM = '0; stat_in = 3'd1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_irmovq();
        test_cmov();
        test_popq_rsp();
        test_pushq();
        test_random();
        test_halt();
        test_async_reset();
        test_reset();
        test_bad_stat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
